// File: rtl/memory_mapping_pkg.sv
// -----------------------------------------------------------------------------
// memory_mapping
//   System address map shared by the CPU front end and the memory controllers,
//   plus the instruction-fetch types.
//   - INST_ROM_BEGIN/END, DATA_RAM_BEGIN/END : region bounds (inclusive)
//   - ifu_state_e   : fetch-unit control states
//   - fetch_entry_t : one fetched word as handed to decode {pc, instr, fault}
// -----------------------------------------------------------------------------
package memory_mapping;

    localparam logic [31:0] INST_ROM_BEGIN = 32'h0000_1000;
    localparam logic [31:0] INST_ROM_END   = 32'h0000_1FFF;
    localparam logic [31:0] DATA_RAM_BEGIN = 32'h0000_2000;
    localparam logic [31:0] DATA_RAM_END   = 32'h0000_2FFF;

    // Byte distance between consecutive sequential fetches.
    localparam logic [31:0] FETCH_STRIDE   = 32'd4;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_RUN  = 2'd1,
        IFU_HALT = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small FIFO of fetch_entry_t between the fetch response and decode.
//   The head entry is held in a register so decode sees a registered
//   {valid, entry}: a word pushed in cycle N is visible in cycle N+1.
//   When the FIFO is empty the head register keeps its last contents.
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active low
//   flush      in   discard all entries (overrides push and pop)
//   push       in   write push_data
//   push_data  in   entry to write
//   pop        in   consume the head entry
//   head_valid out  FIFO non-empty
//   head_data  out  oldest entry
//   count      out  number of stored entries
// Parameters
//   DEPTH      entries, power of two, >= 2
// -----------------------------------------------------------------------------
module fetch_fifo
    import memory_mapping::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output logic               head_valid,
    output fetch_entry_t       head_data,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    fetch_entry_t     head_reg;
    fetch_entry_t     head_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        head_next   = head_reg;
        if (count_next != '0) begin
            // If nothing older survives this cycle, the new head is the word
            // being written right now and is not in the array yet.
            if (do_push && ((count_reg - CNT_W'(do_pop)) == '0)) begin
                head_next = push_data;
            end else begin
                head_next = mem_reg[rd_ptr_next];
            end
        end
    end

    // Storage array: no reset, pointers define what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = head_reg;
    assign count      = count_reg;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch front end. Owns the PC, issues single-word reads to
//   inst_mem_ctrl, captures the word one cycle later and queues
//   {pc, instr, fault} for decode over a valid/ready handshake.
//   A redirect loads a new PC and flushes the queue and any in-flight read.
//   A fetch from an unmapped or misaligned PC produces one faulting entry and
//   stops fetching until the next redirect.
// Ports
//   clk, rst (sync, active low)
//   redirect_valid/redirect_pc   branch/jump target
//   imem_rd/imem_addr            read request to inst_mem_ctrl
//   imem_cmp/imem_instr          region decode and read data from inst_mem_ctrl
//   if_valid/if_ready            handshake to decode
//   if_pc/if_instr/if_fault      head entry
//   perf_fetch_cnt/perf_stall_cnt  only when IFU_PERF_CNT_EN is defined
// Parameters
//   RESET_PC   PC after reset
//   BUF_DEPTH  fetch FIFO entries (power of two, >= 2)
// Build option
//   IFU_PERF_CNT_EN : adds the two performance counters
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import memory_mapping::*;
#(
    parameter logic [31:0] RESET_PC  = INST_ROM_BEGIN,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [1:0]  imem_cmp,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    ifu_state_e       state_reg;
    ifu_state_e       state_next;
    logic [31:0]      pc_reg;
    logic             inflight_reg;
    logic [31:0]      inflight_pc_reg;
    logic             inflight_fault_reg;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_valid;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             push;
    logic             issue;
    logic             fault_now;
    logic [CNT_W:0]   occupancy;

    assign pop       = fifo_valid && if_ready;
    // A response arriving in a redirect cycle belongs to the old path.
    assign push      = inflight_reg && !redirect_valid;
    assign fault_now = (imem_cmp == 2'b00) || (pc_reg[1:0] != 2'b00);

    // Entries the FIFO will hold after this cycle; the in-flight word already
    // owns a slot, so the FIFO can never be overrun.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
    assign issue     = rst && (state_reg == IFU_RUN) && !redirect_valid &&
                       (occupancy < (CNT_W + 1)'(BUF_DEPTH));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IFU_IDLE: state_next = IFU_RUN;
            IFU_RUN:  if (issue && fault_now) state_next = IFU_HALT;
            IFU_HALT: state_next = IFU_HALT;
            default:  state_next = IFU_IDLE;
        endcase
        if (redirect_valid) begin
            state_next = IFU_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg          <= IFU_IDLE;
            pc_reg             <= RESET_PC;
            inflight_reg       <= 1'b0;
            inflight_pc_reg    <= '0;
            inflight_fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (redirect_valid) begin
                pc_reg       <= redirect_pc;
                inflight_reg <= 1'b0;
            end else begin
                // A faulting fetch leaves the PC on the offending address.
                if (issue && !fault_now) begin
                    pc_reg <= pc_reg + FETCH_STRIDE;
                end
                inflight_reg <= issue;
                if (issue) begin
                    inflight_pc_reg    <= pc_reg;
                    inflight_fault_reg <= fault_now;
                end
            end
        end
    end

    always_comb begin
        push_entry.pc    = inflight_pc_reg;
        push_entry.instr = inflight_fault_reg ? 32'd0 : imem_instr;
        push_entry.fault = inflight_fault_reg;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

    assign imem_rd   = issue;
    assign imem_addr = pc_reg;
    assign if_valid  = fifo_valid;
    assign if_pc     = head_entry.pc;
    assign if_instr  = head_entry.instr;
    assign if_fault  = head_entry.fault;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (push && !inflight_fault_reg) begin
                perf_fetch_reg <= perf_fetch_reg + 32'd1;
            end
            if (fifo_valid && !if_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_stall_cnt = perf_stall_reg;
`endif

endmodule
